dmem_bus_arbiter: RTL and testbench
===================================

Name: dmem_bus_arbiter

Overview:
Shares the single data-memory / memory-mapped-IO port (the DMem controller plus IO controller path) between two requesters: port 0 = CPU load/store, port 1 = debug/loader master.
- Round-robin arbitration.
- Registers each granted transaction and drives it onto the shared bus for exactly one cycle.
- Waits a fixed read latency, then returns a one-cycle ack with read data.
- Flags IO-space accesses so the downstream decode needs no extra address logic.

Parameters:
DBITS, 32, data and address width
READ_LATENCY, 1, cycles from mem_en cycle to mem_rdata valid (legal 1..7)
IO_BASE_NIBBLE, 4'hF, addr[DBITS-1:DBITS-4] value that selects IO space

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req0  in  1  port-0 request, held until ack0
we0  in  1  port-0 write enable
addr0  in  DBITS  port-0 byte address
wdata0  in  DBITS  port-0 write data
ack0  out  1  port-0 completion pulse
rdata0  out  DBITS  port-0 read data, valid with ack0
req1, we1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1
mem_en  out  1  shared-bus access strobe
mem_we  out  1  shared-bus write enable
mem_addr  out  DBITS  shared-bus address
mem_wdata  out  DBITS  shared-bus write data
mem_is_io  out  1  mem_addr top nibble == IO_BASE_NIBBLE
mem_rdata  in  DBITS  shared-bus read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE; all outputs 0; rr pointer prefers port 0; latched addr/wdata/rdata = 0.
- States:
  - IDLE: sample req0/req1.
    - Neither high: stay in IDLE.
    - One high: grant it.
    - Both high: grant the port not served last; after reset, port 0 first.
    - On grant: latch port id, we, addr, wdata; go to ISSUE.
  - ISSUE (1 cycle): mem_en=1; mem_we, mem_addr, mem_wdata, mem_is_io from latches. Write goes to RESP. Read goes to WAIT with cnt=READ_LATENCY-1.
  - WAIT: cnt==0 captures mem_rdata into rdata latch and goes to RESP; otherwise cnt-1. With READ_LATENCY=1, WAIT lasts one cycle.
  - RESP (1 cycle): ack of the granted port =1 and the other ack =0. rdataN is driven with the captured value; it holds its last value otherwise. Update rr pointer, then go to IDLE.
- Latency from the cycle req is first sampled in IDLE (N):
  - Write: mem_en at N+1, ack at N+2.
  - Read: mem_en at N+1, ack at N+2+READ_LATENCY.
  - Next grant is possible at N+3 (write) or N+3+READ_LATENCY (read).
- Handshake:
  - A requester holds req/we/addr/wdata stable until ack.
  - A requester deasserts req on the same edge that samples ack. If req is still high in IDLE, that is a new back-to-back request.
  - Transactions are captured at grant. Dropping req after grant does not cancel; ack still pulses.
- mem_en, mem_we and mem_wdata are 0 outside ISSUE. mem_addr and mem_is_io hold the latched value.
- Exactly one ack high per transaction; ack0 and ack1 never high together.
- Starvation bound: a held request is granted within one other transaction.
- reset_n low mid-transaction: immediate return to IDLE, outputs cleared, no ack issued. A requester must reissue after reset.
- Addresses are passed unchanged. No alignment checking; word indexing is downstream.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, ISSUE, WAIT, RESP; 2 bits)
  - IO_BASE_NIBBLE default
  - port-id constants PORT_CPU=0, PORT_DBG=1
- One sub-module: rr_arbiter2.
  - Combinational grant from req0, req1 and a last-served bit.
  - Registered pointer update on an advance strobe driven in RESP.
- FSM, latches and latency counter live in the top.

Test Plan:
1. Reset, then port-0 write addr=0x100, wdata=0xDEADBEEF -> mem_en/mem_we=1 at N+1 with mem_addr=0x100 and mem_is_io=0; ack0 at N+2; ack1 stays 0.
2. Port-1 read addr=0xF0000014, mem_rdata=0x3FF, READ_LATENCY=1 -> mem_is_io=1 at N+1; ack1 at N+3 with rdata1=0x3FF.
3. req0 and req1 both high from reset, both reissue back-to-back for 4 transactions -> grant order 0,1,0,1; no ack overlap.
4. READ_LATENCY=3, port-0 read -> mem_en only at N+1; mem_rdata captured at N+4; ack0 at N+5; busy high N+1..N+5.
5. Port-1 read granted, req1 dropped during WAIT -> ack1 still pulses at the scheduled cycle; IDLE follows.
6. reset_n pulsed low during WAIT -> all outputs 0 asynchronously; no ack; next request after release is served from IDLE with port 0 preferred.

Source files
------------

// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory / IO bus arbiter.
package dmem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] IO_BASE_NIBBLE_DEF = 4'hF;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; a held request never waits behind more than one other grant.
// Latency: grant is combinational; the last-served pointer updates on the advance strobe.
// Backpressure: none; requesters simply hold req until served.
module rr_arbiter2
  import dmem_bus_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  input  logic served,
  output logic gnt_vld,
  output logic gnt_port
);

  logic last_served;

  always_comb begin
    gnt_vld  = req0 | req1;
    gnt_port = PORT_CPU;
    if (req0 && req1) begin
      gnt_port = ~last_served;
    end else if (req1) begin
      gnt_port = PORT_DBG;
    end
  end

  // Starting as "port 1 served last" makes port 0 win the first contested grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_served <= PORT_DBG;
    end else if (advance) begin
      last_served <= served;
    end
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Shares the DMem/IO bus between CPU (port 0) and debug/loader (port 1), one transaction at a time.
// Latency: mem_en one cycle after grant; ack after 2 cycles (write) or 2+READ_LATENCY (read).
// Backpressure: requesters hold req until their ack pulse; the loser waits for at most one transaction.
module dmem_bus_arbiter
  import dmem_bus_arbiter_pkg::*;
#(
  parameter int unsigned DBITS          = 32,
  parameter int unsigned READ_LATENCY   = 1,
  parameter logic [3:0]  IO_BASE_NIBBLE = IO_BASE_NIBBLE_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             we0,
  input  logic [DBITS-1:0] addr0,
  input  logic [DBITS-1:0] wdata0,
  output logic             ack0,
  output logic [DBITS-1:0] rdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [DBITS-1:0] addr1,
  input  logic [DBITS-1:0] wdata1,
  output logic             ack1,
  output logic [DBITS-1:0] rdata1,
  output logic             mem_en,
  output logic             mem_we,
  output logic [DBITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_wdata,
  output logic             mem_is_io,
  input  logic [DBITS-1:0] mem_rdata,
  output logic             busy
);

  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

  state_t           state;
  state_t           state_nxt;
  logic             gnt_vld;
  logic             gnt_port;
  logic             port_q;
  logic             we_q;
  logic             io_q;
  logic [DBITS-1:0] addr_q;
  logic [DBITS-1:0] wdata_q;
  logic [DBITS-1:0] rdata0_q;
  logic [DBITS-1:0] rdata1_q;
  logic [2:0]       cnt;
  logic             sel_we;
  logic [DBITS-1:0] sel_addr;
  logic [DBITS-1:0] sel_wdata;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .reset_n  (reset_n),
    .req0     (req0),
    .req1     (req1),
    .advance  (state == ST_RESP),
    .served   (port_q),
    .gnt_vld  (gnt_vld),
    .gnt_port (gnt_port)
  );

  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (gnt_port == PORT_DBG) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt_vld) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_wdata = wdata_q;
        state_nxt = we_q ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == 3'd0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        ack0      = (port_q == PORT_CPU);
        ack1      = (port_q == PORT_DBG);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The IO flag is decoded once at grant so the bus side sees a stable registered bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_q   <= PORT_CPU;
      we_q     <= 1'b0;
      io_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            port_q  <= gnt_port;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            io_q    <= (sel_addr[DBITS-1 -: 4] == IO_BASE_NIBBLE);
          end
        end
        ST_ISSUE: begin
          if (!we_q) cnt <= CNT_INIT;
        end
        ST_WAIT: begin
          if (cnt == 3'd0) begin
            if (port_q == PORT_DBG) rdata1_q <= mem_rdata;
            else                    rdata0_q <= mem_rdata;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_is_io = io_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed scoreboard bench: instance 0 uses READ_LATENCY=1, instance 1 uses READ_LATENCY=3.
module tb_dmem_bus_arbiter;

  typedef struct {
    int          key;   // dut*2 + (0 = bus strobe, 1 = ack)
    int          cyc;
    logic        port;
    logic        we;
    logic        io;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];

  logic [1:0]  req0 = '0, we0 = '0, req1 = '0, we1 = '0;
  logic [31:0] addr0 [2], wdata0 [2], addr1 [2], wdata1 [2], mem_rdata [2];
  logic [1:0]  ack0, ack1, mem_en, mem_we, mem_is_io, busy;
  logic [31:0] rdata0 [2], rdata1 [2], mem_addr [2], mem_wdata [2];
  int          rd_cyc [2];
  logic [31:0] rd_val [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read data is only correct in the one cycle the arbiter must sample it.
  assign mem_rdata[0] = (cyc == rd_cyc[0]) ? rd_val[0] : 32'hBAD0_BAD0;
  assign mem_rdata[1] = (cyc == rd_cyc[1]) ? rd_val[1] : 32'hBAD0_BAD0;

  dmem_bus_arbiter #(.DBITS(32), .READ_LATENCY(1), .IO_BASE_NIBBLE(4'hF)) u_dut1 (
    .clk(clk), .reset_n(rst_n),
    .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]), .ack0(ack0[0]), .rdata0(rdata0[0]),
    .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]), .ack1(ack1[0]), .rdata1(rdata1[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_is_io(mem_is_io[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  dmem_bus_arbiter #(.DBITS(32), .READ_LATENCY(3), .IO_BASE_NIBBLE(4'hF)) u_dut3 (
    .clk(clk), .reset_n(rst_n),
    .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]), .ack0(ack0[1]), .rdata0(rdata0[1]),
    .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]), .ack1(ack1[1]), .rdata1(rdata1[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_is_io(mem_is_io[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit pop_exp(input int key, output exp_t e);
    e = '{default: '0};
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].key == key) begin
        e = sb[i];
        sb.delete(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic push(input int d, input int n, input logic p, input logic we, input logic [31:0] a,
                      input logic [31:0] w, input logic [31:0] rv, input logic io, input bit with_ack);
    exp_t e;
    e.key = d * 2; e.cyc = n + 1; e.port = p; e.we = we; e.io = io;
    e.addr = a; e.wdata = w; e.rdata = rv;
    sb.push_back(e);
    if (with_ack) begin
      e.key = d * 2 + 1;
      e.cyc = we ? n + 2 : n + 2 + lat_of(d);
      sb.push_back(e);
    end
  endtask

  task automatic set_req(input int d, input logic p, input logic we, input logic [31:0] a, input logic [31:0] w);
    if (p == 1'b0) begin
      req0[d] = 1'b1; we0[d] = we; addr0[d] = a; wdata0[d] = w;
    end else begin
      req1[d] = 1'b1; we1[d] = we; addr1[d] = a; wdata1[d] = w;
    end
  endtask

  task automatic clr_req(input int d, input logic p);
    if (p == 1'b0) req0[d] = 1'b0;
    else           req1[d] = 1'b0;
  endtask

  task automatic wait_ack_drop(input int d, input logic p);
    bit seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      @(negedge clk);
      seen = p ? ack1[d] : ack0[d];
    end
    chk($sformatf("ack_timeout_d%0d_p%0d", d, p), 32'(seen), 32'd1);
    @(posedge clk); #1;
    clr_req(d, p);
  endtask

  task automatic run_txn(input int d, input logic p, input logic we, input logic [31:0] a,
                         input logic [31:0] w, input logic [31:0] rv, input logic io);
    int n;
    @(posedge clk); #1;
    n = cyc;
    set_req(d, p, we, a, w);
    rd_cyc[d] = n + 1 + lat_of(d);
    rd_val[d] = rv;
    push(d, n, p, we, a, w, rv, io, 1'b1);
    wait_ack_drop(d, p);
  endtask

  task automatic check_zero(input int d, input string tag);
    chk($sformatf("%s_ctrl_d%0d", tag, d),
        32'({busy[d], ack0[d], ack1[d], mem_en[d], mem_we[d], mem_is_io[d]}), 32'd0);
    chk($sformatf("%s_addr_d%0d", tag, d), mem_addr[d], 32'd0);
    chk($sformatf("%s_wdata_d%0d", tag, d), mem_wdata[d], 32'd0);
    chk($sformatf("%s_rdata0_d%0d", tag, d), rdata0[d], 32'd0);
    chk($sformatf("%s_rdata1_d%0d", tag, d), rdata1[d], 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    req0 = '0; req1 = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  // Monitor: every bus strobe and every ack must match the oldest expectation of its kind.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        if (ack0[d] && ack1[d]) chk($sformatf("ack_overlap_d%0d", d), 32'd1, 32'd0);
        if (!mem_en[d]) chk($sformatf("bus_quiet_d%0d", d), 32'({mem_we[d], mem_wdata[d]}), 32'd0);
        if (mem_en[d]) begin
          if (!pop_exp(d * 2, e)) begin
            chk($sformatf("unexpected_mem_en_d%0d", d), 32'd1, 32'd0);
          end else begin
            chk($sformatf("bus_cycle_d%0d", d), 32'(cyc), 32'(e.cyc));
            chk($sformatf("bus_we_d%0d", d), 32'(mem_we[d]), 32'(e.we));
            chk($sformatf("bus_addr_d%0d", d), mem_addr[d], e.addr);
            chk($sformatf("bus_is_io_d%0d", d), 32'(mem_is_io[d]), 32'(e.io));
            if (e.we) chk($sformatf("bus_wdata_d%0d", d), mem_wdata[d], e.wdata);
          end
        end
        if (ack0[d] || ack1[d]) begin
          if (!pop_exp(d * 2 + 1, e)) begin
            chk($sformatf("unexpected_ack_d%0d", d), 32'd1, 32'd0);
          end else begin
            chk($sformatf("ack_cycle_d%0d", d), 32'(cyc), 32'(e.cyc));
            chk($sformatf("ack_port_d%0d", d), 32'(ack1[d]), 32'(e.port));
            if (!e.we) chk($sformatf("ack_rdata_d%0d", d), e.port ? rdata1[d] : rdata0[d], e.rdata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      addr0[d] = '0; wdata0[d] = '0; addr1[d] = '0; wdata1[d] = '0;
      rd_cyc[d] = -1; rd_val[d] = '0;
    end
    @(negedge clk);
    check_zero(0, "reset");
    check_zero(1, "reset");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // 1: CPU write, RAM space
    run_txn(0, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0);
    @(negedge clk);
    chk("addr_held_after_write", mem_addr[0], 32'h0000_0100);

    // 2: debug read, IO space
    run_txn(0, 1'b1, 1'b0, 32'hF000_0014, 32'h0, 32'h0000_03FF, 1'b1);

    // 3: both requesters held from reset -> alternating 0,1,0,1
    do_reset();
    @(posedge clk); #1;
    n = cyc;
    set_req(0, 1'b0, 1'b1, 32'h0000_0200, 32'h1111_1111);
    set_req(0, 1'b1, 1'b1, 32'hF000_0200, 32'h2222_2222);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push(0, n + 3 * k, 1'b0, 1'b1, 32'h0000_0200, 32'h1111_1111, 32'h0, 1'b0, 1'b1);
      else            push(0, n + 3 * k, 1'b1, 1'b1, 32'hF000_0200, 32'h2222_2222, 32'h0, 1'b1, 1'b1);
    end
    repeat (12) @(posedge clk);
    #1;
    req0[0] = 1'b0; req1[0] = 1'b0;

    // 4: READ_LATENCY=3 CPU read with busy profile
    @(posedge clk); #1;
    n = cyc;
    set_req(1, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
    rd_cyc[1] = n + 4;
    rd_val[1] = 32'hCAFE_F00D;
    push(1, n, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("busy_lat3_c%0d", c), 32'(busy[1]), (c >= 1) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    clr_req(1, 1'b0);
    @(negedge clk);
    chk("busy_lat3_after", 32'(busy[1]), 32'd0);

    // 5: debug read, req dropped during WAIT, ack still arrives
    @(posedge clk); #1;
    n = cyc;
    set_req(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
    rd_cyc[0] = n + 2;
    rd_val[0] = 32'h0000_0055;
    push(0, n, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h0000_0055, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    clr_req(0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_after_drop", 32'(busy[0]), 32'd0);
    chk("rdata1_holds", rdata1[0], 32'h0000_0055);

    // 6: reset during WAIT clears everything; afterwards port 0 wins again
    run_txn(0, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_AAAA, 32'h0, 1'b0);
    @(posedge clk); #1;
    n = cyc;
    set_req(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    push(0, n, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(0, "midreset");
    req0 = '0; req1 = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n = cyc;
    set_req(0, 1'b0, 1'b1, 32'h0000_0500, 32'h5050_5050);
    set_req(0, 1'b1, 1'b1, 32'h0000_0504, 32'h0505_0505);
    push(0, n, 1'b0, 1'b1, 32'h0000_0500, 32'h5050_5050, 32'h0, 1'b0, 1'b1);
    push(0, n + 3, 1'b1, 1'b1, 32'h0000_0504, 32'h0505_0505, 32'h0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    clr_req(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    clr_req(0, 1'b1);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
